gate3_sweep_ctrl: RTL and testbench

GATE3_SWEEP_CTRL -- requirements
Module: gate3_sweep_ctrl

---
 rtl/gate3_sweep_ctrl.sv | 128 ++++++++++++
 tb/tb_gate3_sweep_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate3_sweep_ctrl.sv
// Exhaustive sweep controller for a 3-input gate: drives all eight {a,b,c} vectors,
// samples f at the end of each hold window and reports result, fail_mask and pass.
// Optional macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching sample.
module gate3_sweep_ctrl #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter logic [7:0]  EXPECT      = 8'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       f,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] result,
  output logic [7:0] fail_mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] abc_q, abc_d;
  logic [7:0] result_q, result_d;
  logic [7:0] fail_mask_q, fail_mask_d;
  logic       pass_q, pass_d;
  logic       mism;
  logic       stop;

  always_comb begin
    // NOTE: every signal written here gets a default first; a missed branch would infer a latch.
    state_d     = state_q;
    vec_d       = vec_q;
    hcnt_d      = hcnt_q;
    abc_d       = abc_q;
    result_d    = result_q;
    fail_mask_d = fail_mask_q;
    pass_d      = pass_q;
    mism        = 1'b0;
    stop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          vec_d       = 3'd0;
          hcnt_d      = 8'd0;
          abc_d       = 3'd0;
          result_d    = 8'h00;
          fail_mask_d = 8'h00;
          pass_d      = 1'b0;
        end
      end

      RUN: begin
        if (abort) begin
          // Already-sampled bits are kept; pass stays at its cleared value.
          state_d = IDLE;
          abc_d   = 3'd0;
        end else if (hcnt_q == HOLD_LAST) begin
          mism                 = f ^ EXPECT[vec_q];
          result_d[vec_q]      = f;
          fail_mask_d[vec_q]   = mism;
          hcnt_d               = 8'd0;
`ifdef SWEEP_STOP_ON_FAIL_EN
          stop = (vec_q == 3'd7) || mism;
`else
          stop = (vec_q == 3'd7);
`endif
          if (stop) begin
            state_d = DONE;
            abc_d   = 3'd0;
            pass_d  = (fail_mask_d == 8'h00);
          end else begin
            vec_d = 3'(vec_q + 3'd1);
            abc_d = 3'(vec_q + 3'd1);
          end
        end else begin
          hcnt_d = 8'(hcnt_q + 8'd1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= 3'd0;
      hcnt_q      <= 8'd0;
      abc_q       <= 3'd0;
      result_q    <= 8'h00;
      fail_mask_q <= 8'h00;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      hcnt_q      <= hcnt_d;
      abc_q       <= abc_d;
      result_q    <= result_d;
      fail_mask_q <= fail_mask_d;
      pass_q      <= pass_d;
    end
  end

  assign {a, b, c}  = abc_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign result     = result_q;
  assign fail_mask  = fail_mask_q;

endmodule

// File: tb/tb_gate3_sweep_ctrl.sv
// Scoreboard bench for gate3_sweep_ctrl: sweeps are predicted from the gate truth table,
// queued at start, and checked by a monitor at every done pulse and every busy cycle.
module tb_gate3_sweep_ctrl;

  localparam int unsigned H   = 4;
  localparam logic [7:0]  EXP = 8'h7F;

  typedef struct {
    int unsigned start_cyc;
    int unsigned done_cyc;
    logic [7:0]  result;
    logic [7:0]  mask;
    logic        pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, abort, f;
  logic a, b, c, busy, done, pass;
  logic [7:0] result, fail_mask;
  logic [7:0] func;

  logic start1, abort1, f1;
  logic a1, b1, c1, busy1, done1, pass1;
  logic [7:0] result1, fail_mask1;

  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign f  = func[{a, b, c}];
  assign f1 = ~(a1 & b1 & c1);

  gate3_sweep_ctrl #(.HOLD_CYCLES(H), .EXPECT(EXP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .f(f),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .result(result), .fail_mask(fail_mask)
  );

  gate3_sweep_ctrl #(.HOLD_CYCLES(1), .EXPECT(EXP)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .f(f1),
    .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .result(result1), .fail_mask(fail_mask1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the sweep captures the gate's truth table vector by vector.
  function automatic exp_t model(input int unsigned s, input logic [7:0] fn);
    exp_t e;
    int unsigned last;
    last = 7;
`ifdef SWEEP_STOP_ON_FAIL_EN
    for (int v = 7; v >= 0; v--)
      if (fn[v] != EXP[v]) last = v;
`endif
    e.start_cyc = s;
    e.result    = 8'h00;
    e.mask      = 8'h00;
    for (int v = 0; v <= int'(last); v++) begin
      e.result[v] = fn[v];
      e.mask[v]   = fn[v] ^ EXP[v];
    end
    e.done_cyc = s + (last + 1) * H + 1;
    e.pass     = (e.mask == 8'h00);
    return e;
  endfunction

  exp_t        mon_head;
  logic        mon_busy;
  int unsigned mon_abc;

  always @(negedge clk) begin
    if (!rst) begin
      if (sb.size() > 0) begin
        mon_head = sb[0];
        mon_busy = (cyc > mon_head.start_cyc) && (cyc < mon_head.done_cyc);
        mon_abc  = mon_busy ? (cyc - mon_head.start_cyc - 1) / H : 0;
        check("busy", 32'(busy), 32'(mon_busy));
        check("abc", 32'({a, b, c}), mon_abc);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_head = sb.pop_front();
          check("done_cycle", cyc, mon_head.done_cyc);
          check("result", 32'(result), 32'(mon_head.result));
          check("fail_mask", 32'(fail_mask), 32'(mon_head.mask));
          check("pass", 32'(pass), 32'(mon_head.pass));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic wait_until(input int unsigned target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      check("sweep_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // rp_off > 0 re-pulses start that many cycles after the accepted start.
  task automatic run_sweep(input logic [7:0] fn, input logic with_abort, input int unsigned rp_off);
    exp_t e;
    @(negedge clk);
    func  = fn;
    start = 1'b1;
    abort = with_abort;
    e = model(cyc, fn);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    if (rp_off > 0) begin
      wait_until(e.start_cyc + rp_off);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    drain();
  endtask

  task automatic expect_all_zero(input string tag);
    check({tag, "_abc"}, 32'({a, b, c}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_fail_mask"}, 32'(fail_mask), 32'd0);
  endtask

  initial begin
    int unsigned s;
    int t;
    logic [7:0] fn;
    rst = 1'b1; start = 1'b0; abort = 1'b0; func = 8'h7F;
    start1 = 1'b0; abort1 = 1'b0;
    repeat (3) @(negedge clk);
    expect_all_zero("reset");
    rst = 1'b0;

    run_sweep(8'h7F, 1'b1, 0);   // ideal NAND, abort alongside start in IDLE
    run_sweep(8'hFF, 1'b0, 0);   // f stuck at 1
    run_sweep(8'h80, 1'b0, 0);   // AND gate
    run_sweep(8'h7F, 1'b0, 15);  // start re-pulsed mid-run

    // Abort in cycle 10: bits 0 and 1 already sampled.
    @(negedge clk);
    func = 8'h7F; start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_abc", 32'({a, b, c}), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result_lo", 32'(result[1:0]), 32'd3);
    check("abort_pass", 32'(pass), 32'd0);
    repeat (40) @(negedge clk);
    run_sweep(8'h7F, 1'b0, 0);

    // Reset in cycle 20 of a running sweep.
    @(negedge clk);
    start = 1'b1; s = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_until(s + 20);
    rst = 1'b1;
    @(negedge clk);
    expect_all_zero("midrun_reset");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    run_sweep(8'h7F, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      fn = ($urandom_range(1, 0) == 1) ? 8'h7F : 8'($urandom);
      run_sweep(fn, 1'($urandom_range(1, 0)),
                ($urandom_range(2, 0) == 0) ? $urandom_range(8 * H + 1, 1) : 0);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end

    // Single-cycle hold variant.
    @(negedge clk);
    start1 = 1'b1; s = cyc;
    @(negedge clk);
    start1 = 1'b0;
    t = 0;
    while (!done1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("h1_done_seen", 32'(done1), 32'd1);
    check("h1_done_cycle", cyc, s + 9);
    check("h1_pass", 32'(pass1), 32'd1);
    check("h1_result", 32'(result1), 32'h7F);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
